// File: rtl/sdr_qsram_ctrl.sv
// SDR synchronous SRAM controller with an integrated array, pipelined reads and a refresh scheduler.
// Optional per-word even parity is enabled with `define SDR_QSRAM_PARITY_EN.
module sdr_qsram_ctrl #(
    parameter int ADDR_WIDTH       = 10,
    parameter int DATA_WIDTH       = 9,
    parameter int READ_LATENCY     = 2,
    parameter int REFRESH_INTERVAL = 64,
    parameter int REFRESH_CYCLES   = 4
) (
    input  logic                  Clock,
    input  logic                  ResetN,
    input  logic                  Enable,
    input  logic                  Read,
    input  logic                  Write,
    input  logic                  Refresh,
    input  logic [ADDR_WIDTH-1:0] Address,
    input  logic [DATA_WIDTH-1:0] WriteData,
`ifdef SDR_QSRAM_PARITY_EN
    input  logic                  ParityInject,
    output logic                  ParityError,
`endif
    output logic                  Ready,
    output logic [DATA_WIDTH-1:0] ReadData,
    output logic                  ReadValid,
    output logic                  RefreshActive
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam int TM_W  = $clog2(REFRESH_INTERVAL);
    localparam int RC_W  = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
`ifdef SDR_QSRAM_PARITY_EN
    localparam int MEM_W = DATA_WIDTH + 1;
`else
    localparam int MEM_W = DATA_WIDTH;
`endif

    typedef enum logic {
        ST_IDLE,
        ST_REFRESH
    } state_t;

    state_t            state, state_nxt;
    logic              pending, pending_nxt;
    logic [TM_W-1:0]   timer, timer_nxt;
    logic [RC_W-1:0]   rcnt, rcnt_nxt;
    logic              timer_tc;

    logic              accept;
    logic              wr_acc;
    logic              rd_acc;
    logic [MEM_W-1:0]  wr_word;
    logic [MEM_W-1:0]  rd_word;

    logic [MEM_W-1:0]  mem [DEPTH];

    logic [READ_LATENCY-1:0] vld_q;
    logic [DATA_WIDTH-1:0]   dat_q [READ_LATENCY];

    // Simultaneous Read and Write is illegal and simply not accepted.
    assign accept = Enable & Ready & (Read ^ Write);
    assign wr_acc = accept & Write;
    assign rd_acc = accept & Read;

`ifdef SDR_QSRAM_PARITY_EN
    assign wr_word = {(^WriteData) ^ ParityInject, WriteData};
`else
    assign wr_word = WriteData;
`endif
    assign rd_word = mem[Address];

    assign timer_tc = (timer == TM_W'(REFRESH_INTERVAL - 1));

    // NOTE: every variable gets a default at the top of always_comb so no path can infer a latch.
    always_comb begin
        state_nxt   = state;
        pending_nxt = pending;
        rcnt_nxt    = rcnt;
        timer_nxt   = timer_tc ? '0 : timer + 1'b1;
        case (state)
            ST_IDLE: begin
                if (pending) begin
                    state_nxt   = ST_REFRESH;
                    pending_nxt = 1'b0;
                    rcnt_nxt    = RC_W'(REFRESH_CYCLES - 1);
                    timer_nxt   = '0;
                end else if (timer_tc || Refresh) begin
                    pending_nxt = 1'b1;
                end
            end
            ST_REFRESH: begin
                if (rcnt == '0) begin
                    state_nxt = ST_IDLE;
                end else begin
                    rcnt_nxt = rcnt - 1'b1;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge Clock or negedge ResetN) begin
        if (!ResetN) begin
            state   <= ST_IDLE;
            pending <= 1'b0;
            timer   <= '0;
            rcnt    <= '0;
        end else begin
            state   <= state_nxt;
            pending <= pending_nxt;
            timer   <= timer_nxt;
            rcnt    <= rcnt_nxt;
        end
    end

    assign Ready         = (state == ST_IDLE) & ~pending;
    assign RefreshActive = (state == ST_REFRESH);

    // NOTE: the storage array has no reset; contents survive ResetN and power-up state is undefined.
    always_ff @(posedge Clock) begin
        if (wr_acc) begin
            mem[Address] <= wr_word;
        end
    end

    // Each stage only loads when valid data arrives, so ReadData holds between valid beats.
    always_ff @(posedge Clock or negedge ResetN) begin
        if (!ResetN) begin
            vld_q <= '0;
            for (int i = 0; i < READ_LATENCY; i++) begin
                dat_q[i] <= '0;
            end
        end else begin
            vld_q[0] <= rd_acc;
            if (rd_acc) begin
                dat_q[0] <= rd_word[DATA_WIDTH-1:0];
            end
            for (int i = 1; i < READ_LATENCY; i++) begin
                vld_q[i] <= vld_q[i-1];
                if (vld_q[i-1]) begin
                    dat_q[i] <= dat_q[i-1];
                end
            end
        end
    end

    assign ReadValid = vld_q[READ_LATENCY-1];
    assign ReadData  = dat_q[READ_LATENCY-1];

`ifdef SDR_QSRAM_PARITY_EN
    logic [READ_LATENCY-1:0] perr_q;

    // With even parity the XOR across data plus stored bit is 0 for an intact word.
    always_ff @(posedge Clock or negedge ResetN) begin
        if (!ResetN) begin
            perr_q <= '0;
        end else begin
            if (rd_acc) begin
                perr_q[0] <= ^rd_word;
            end
            for (int i = 1; i < READ_LATENCY; i++) begin
                if (vld_q[i-1]) begin
                    perr_q[i] <= perr_q[i-1];
                end
            end
        end
    end

    assign ParityError = vld_q[READ_LATENCY-1] & perr_q[READ_LATENCY-1];
`endif

endmodule

// File: tb/tb_sdr_qsram_ctrl.sv
// Directed bench for sdr_qsram_ctrl: scoreboard of expected reads checked by a negedge monitor,
// plus refresh scheduling, illegal requests and reset-abort checks.
module tb_sdr_qsram_ctrl;

    localparam int ADDR_W = 10;
    localparam int DATA_W = 9;
    localparam int LAT    = 2;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              enable, read, write, refresh;
    logic [ADDR_W-1:0] address;
    logic [DATA_W-1:0] write_data;
    logic              ready;
    logic [DATA_W-1:0] read_data;
    logic              read_valid;
    logic              refresh_active;
`ifdef SDR_QSRAM_PARITY_EN
    logic              parity_inject;
    logic              parity_error;
`endif

    typedef struct {
        logic [DATA_W-1:0] data;
        int                due;
        logic              perr;
    } exp_t;

    exp_t sb[$];
    int   cyc   = 0;
    int   base  = 0;
    int   tests = 0;
    int   fails = 0;

    sdr_qsram_ctrl #(
        .ADDR_WIDTH      (ADDR_W),
        .DATA_WIDTH      (DATA_W),
        .READ_LATENCY    (LAT),
        .REFRESH_INTERVAL(64),
        .REFRESH_CYCLES  (4)
    ) dut (
        .Clock        (clk),
        .ResetN       (rst_n),
        .Enable       (enable),
        .Read         (read),
        .Write        (write),
        .Refresh      (refresh),
        .Address      (address),
        .WriteData    (write_data),
`ifdef SDR_QSRAM_PARITY_EN
        .ParityInject (parity_inject),
        .ParityError  (parity_error),
`endif
        .Ready        (ready),
        .ReadData     (read_data),
        .ReadValid    (read_valid),
        .RefreshActive(refresh_active)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        enable  = 1'b0;
        read    = 1'b0;
        write   = 1'b0;
        refresh = 1'b0;
`ifdef SDR_QSRAM_PARITY_EN
        parity_inject = 1'b0;
`endif
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        idle_inputs();
        sb.delete();
        repeat (2) tick();
        rst_n = 1'b1;
        base  = cyc;
    endtask

    task automatic wr(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d, input logic inj);
        enable     = 1'b1;
        write      = 1'b1;
        address    = a;
        write_data = d;
`ifdef SDR_QSRAM_PARITY_EN
        parity_inject = inj;
`else
        if (inj) write_data = d;
`endif
        tick();
        idle_inputs();
    endtask

    task automatic rd(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d, input logic perr);
        check("rd_ready", 32'(ready), 1);
        enable  = 1'b1;
        read    = 1'b1;
        address = a;
        sb.push_back('{data: d, due: cyc + LAT, perr: perr});
        tick();
        idle_inputs();
    endtask

    // Scoreboard monitor: every ReadValid must match the oldest outstanding read, on time.
    always @(negedge clk) begin
        if (rst_n) begin
            if (read_valid) begin
                if (sb.size() == 0) begin
                    check("rv_spurious", 32'(read_valid), 0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("rd_latency", cyc, e.due);
                    check("rd_data", 32'(read_data), 32'(e.data));
`ifdef SDR_QSRAM_PARITY_EN
                    check("rd_parity", 32'(parity_error), 32'(e.perr));
`endif
                end
            end else if (sb.size() != 0 && sb[0].due <= cyc) begin
                check("rv_missing", 32'(read_valid), 1);
                void'(sb.pop_front());
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int fall1, fall2, rise1, ra1, ra2, ra_len, lows;
        logic prev_ready, prev_ra;

        rst_n      = 1'b0;
        address    = '0;
        write_data = '0;
        idle_inputs();
        #7;
        check("rst_ready", 32'(ready), 1);
        check("rst_rvalid", 32'(read_valid), 0);
        check("rst_rdata", 32'(read_data), 0);
        check("rst_ractive", 32'(refresh_active), 0);

        // Basic write/read, back-to-back reads, illegal request.
        do_reset();
        wr(10'h010, 9'h1A5, 1'b0);
        rd(10'h010, 9'h1A5, 1'b0);
        for (int i = 0; i < 4; i++) wr(10'(i), 9'(i + 1), 1'b0);
        for (int i = 0; i < 4; i++) rd(10'(i), 9'(i + 1), 1'b0);
        repeat (4) tick();
        check("hold_rvalid", 32'(read_valid), 0);
        check("hold_rdata", 32'(read_data), 32'h004);
        wr(10'd5, 9'h123, 1'b0);
        enable = 1'b1; read = 1'b1; write = 1'b1; address = 10'd5; write_data = 9'h0FF;
        tick();
        idle_inputs();
        tick();
        rd(10'd5, 9'h123, 1'b0);
        repeat (3) tick();

        // Automatic refresh schedule from a fresh reset.
        do_reset();
        fall1 = -1; fall2 = -1; rise1 = -1; ra1 = -1; ra2 = -1; ra_len = 0;
        prev_ready = 1'b1; prev_ra = 1'b0;
        for (int i = 1; i <= 140; i++) begin
            tick();
            if (prev_ready && !ready) begin
                if (fall1 < 0) fall1 = i; else if (fall2 < 0) fall2 = i;
            end
            if (!prev_ready && ready && rise1 < 0) rise1 = i;
            if (refresh_active && !prev_ra) begin
                if (ra1 < 0) ra1 = i; else if (ra2 < 0) ra2 = i;
            end
            if (refresh_active && ra2 < 0) ra_len++;
            prev_ready = ready;
            prev_ra    = refresh_active;
        end
        check("ready_fall_tc", fall1, 64);
        check("refresh_entry", ra1, 65);
        check("refresh_len", ra_len, 4);
        check("ready_return", rise1, 69);
        check("next_pending", fall2, 129);
        check("next_entry", ra2, 130);

        // Read just before pending drains during REFRESH; refresh pulses merge or force.
        do_reset();
        wr(10'h3FF, 9'h0AB, 1'b0);
        repeat (62) tick();
        rd(10'h3FF, 9'h0AB, 1'b0);
        check("pend_ready", 32'(ready), 0);
        tick();
        check("drain_rvalid", 32'(read_valid), 1);
        check("drain_ractive", 32'(refresh_active), 1);
        tick();
        refresh = 1'b1;
        tick();
        idle_inputs();
        tick();
        check("ref_last_cycle", 32'(refresh_active), 1);
        tick();
        check("ref_exit", 32'(refresh_active), 0);
        check("ref_exit_ready", 32'(ready), 1);
        lows = 0;
        repeat (31) begin
            tick();
            if (!ready || refresh_active) lows++;
        end
        check("no_merged_refresh", lows, 0);
        refresh = 1'b1;
        tick();
        idle_inputs();
        check("force_pending", 32'(ready), 0);
        enable = 1'b1; read = 1'b1; address = 10'h3FF;
        tick();
        idle_inputs();
        check("force_refresh", 32'(refresh_active), 1);
        repeat (8) tick();
        check("force_done_ready", 32'(ready), 1);

        // Reset mid-refresh and reset with a read in flight.
        do_reset();
        enable = 1'b1; read = 1'b1; address = 10'h3FF; refresh = 1'b1;
        sb.push_back('{data: 9'h0AB, due: cyc + LAT, perr: 1'b0});
        tick();
        idle_inputs();
        check("combo_pending", 32'(ready), 0);
        tick();
        check("combo_ractive", 32'(refresh_active), 1);
        check("combo_rdata", 32'(read_data), 32'h0AB);
        tick();
        check("ref2_ractive", 32'(refresh_active), 1);
        rst_n = 1'b0;
        #1;
        check("abort_ractive", 32'(refresh_active), 0);
        check("abort_ready", 32'(ready), 1);
        check("abort_rvalid", 32'(read_valid), 0);
        check("abort_rdata", 32'(read_data), 0);
        do_reset();
        rd(10'h010, 9'h1A5, 1'b0);
        #2;
        rst_n = 1'b0;
        sb.delete();
        #1;
        check("flight_rvalid", 32'(read_valid), 0);
        tick();
        check("flight_rvalid_edge", 32'(read_valid), 0);
        rst_n = 1'b1;
        base  = cyc;
        lows  = 0;
        repeat (4) begin
            tick();
            if (read_valid) lows++;
        end
        check("flight_no_rvalid", lows, 0);
        check("flight_ready", 32'(ready), 1);

`ifdef SDR_QSRAM_PARITY_EN
        do_reset();
        wr(10'd7, 9'h055, 1'b1);
        wr(10'd8, 9'h155, 1'b0);
        rd(10'd7, 9'h055, 1'b1);
        rd(10'd8, 9'h155, 1'b0);
        repeat (4) tick();
`endif

        check("sb_drained", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
